infix_calc_engine: RTL
======================

INFIX_CALC_ENGINE -- requirements
Module: infix_calc_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result bit width.
REQ-002 SHALL have parameter DEPTH, default 64, entries in each of the operand stack and the operator stack.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have tok_valid input 1, tok_ready output 1: token handshake; transfer when both high on a rising edge.
REQ-006 SHALL have tok_kind input 3: 000 ADD, 001 MUL, 010 LPAREN, 011 RPAREN, 100 OPERAND, 101 END, 110 SUB, 111 reserved.
REQ-007 SHALL have tok_data input WIDTH: operand value, used only when tok_kind=OPERAND.
REQ-008 SHALL have res_valid output 1, res_ready input 1: result handshake.
REQ-009 SHALL have res_data output WIDTH, res_ovf output 1, res_err output 1, all qualified by res_valid.
REQ-010 SHALL have busy output 1, high whenever the FSM is not in ACCEPT.

Function
REQ-011 SHALL implement the FSM states ACCEPT, REDUCE, FINISH, RESULT.
REQ-012 SHALL drive tok_ready=1 only in ACCEPT, and SHALL latch each accepted token into a pending-token register.
REQ-013 On OPERAND, SHALL push tok_data to the operand stack and stay in ACCEPT.
REQ-014 On an operator, SHALL enter REDUCE while the top operator is not LPAREN and has precedence >= the pending operator (MUL > ADD = SUB), then push the pending operator and return to ACCEPT.
REQ-015 REDUCE SHALL pop one operator and two operands per cycle and push the result, so each reduction costs exactly one cycle.
REQ-016 On LPAREN, SHALL push it with no reduction; on RPAREN, SHALL reduce until LPAREN is on top and then pop it.
REQ-017 On END, SHALL enter FINISH, reduce one operator per cycle until the operator stack is empty, then enter RESULT the next cycle.
REQ-018 In RESULT, SHALL hold res_valid=1 and keep outputs stable until res_ready=1, then clear both stacks and flags and return to ACCEPT.
REQ-019 Arithmetic SHALL be unsigned modulo 2^WIDTH; res_ovf SHALL be sticky for the expression and set on any carry out, borrow, or nonzero upper product half.
REQ-020 Syntax errors SHALL set sticky res_err and discard tokens until END: operand after operand, operator without a left operand, RPAREN with no LPAREN, END with LPAREN open, END with operand count != 1, or reserved kind.
REQ-021 A push to a full stack (DEPTH entries) SHALL set res_err; the push SHALL be dropped and no entry overwritten.
REQ-022 When res_err=1, res_data SHALL be 0 and res_ovf SHALL be 0.
REQ-023 An expression containing only END SHALL return res_err=1.

Reset
REQ-024 While rst=1, the FSM SHALL be in ACCEPT, both stack pointers 0, and outputs as follows: tok_ready=1 (after release), res_valid=0, res_data=0, res_ovf=0, res_err=0, busy=0.
REQ-025 rst asserted mid-expression or during RESULT SHALL discard all state, with no result emitted.

Configuration
REQ-026 Macro CALC_SUB_EN: when defined, SUB SHALL be a left-associative operator at ADD precedence, computing a-b modulo 2^WIDTH with borrow setting res_ovf.
REQ-027 When CALC_SUB_EN is undefined, tok_kind=110 SHALL be treated as reserved and set res_err.

Structure
REQ-028 Package calc_pkg SHALL hold the tok_kind encoding enum, the operator enum, the FSM state enum, and the precedence function.
REQ-029 SHALL instantiate a parametrised sub-module calc_lifo (WIDTH, DEPTH; push/pop/top/full/empty) twice: once for operands and once for operators.

Verification
REQ-030 Tokens 2 + 3 * 4 END with res_ready=1 -> res_data=14, ovf=0, err=0; END acceptance to res_valid = 3 cycles (2 reductions + 1).
REQ-031 Tokens ( 2 + 3 ) * 4 END -> res_data=20; tok_ready low for exactly 1 cycle after RPAREN.
REQ-032 WIDTH=16, tokens 300 * 300 END -> res_data=24464, res_ovf=1; the next expression 1 + 1 END -> 2, res_ovf=0.
REQ-033 Tokens ) 5 END -> res_err=1, res_data=0; with DEPTH=4, five LPAREN -> res_err=1 and no stack corruption (the next expression 7 END -> 7).
REQ-034 rst pulsed after tokens 5 * ( -> no res_valid; then 9 END -> 9; res_ready held 0 for 5 cycles -> res_valid and res_data stable.
REQ-035 With CALC_SUB_EN, 10 - 3 - 2 END -> 5 and 2 - 3 END -> 65535 with res_ovf=1; without it, 10 - 3 END -> res_err=1.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the infix calculator engine.
// Holds the token-kind encoding, the stacked-operator encoding, the FSM
// state encoding and the operator precedence function.
package calc_pkg;

  typedef enum logic [2:0] {
    TK_ADD     = 3'b000,
    TK_MUL     = 3'b001,
    TK_LPAREN  = 3'b010,
    TK_RPAREN  = 3'b011,
    TK_OPERAND = 3'b100,
    TK_END     = 3'b101,
    TK_SUB     = 3'b110,
    TK_RSVD    = 3'b111
  } tok_kind_e;

  // Encoding of entries held on the operator stack.
  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_MUL    = 2'd1,
    OP_SUB    = 2'd2,
    OP_LPAREN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_REDUCE = 2'd1,
    ST_FINISH = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam int OP_W = 2;

  // MUL binds tighter than ADD/SUB; LPAREN never wins a precedence compare.
  function automatic logic [1:0] op_prec(input op_e op);
    case (op)
      OP_MUL:         op_prec = 2'd2;
      OP_ADD, OP_SUB: op_prec = 2'd1;
      default:        op_prec = 2'd0;
    endcase
  endfunction

  function automatic op_e kind_to_op(input tok_kind_e k);
    case (k)
      TK_MUL:    kind_to_op = OP_MUL;
      TK_SUB:    kind_to_op = OP_SUB;
      TK_LPAREN: kind_to_op = OP_LPAREN;
      default:   kind_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_lifo.sv
// calc_lifo: register-file stack with combined pop/push per cycle.
// Each cycle first pops pop_n_i entries (0..2), then optionally pushes
// din_i on the shortened stack, so "pop two, push one" replaces a pair by
// its result in a single cycle. A push onto a full stack is dropped and
// nothing is overwritten. DEPTH must be at least 2.
module calc_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [1:0]                 pop_n_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [WIDTH-1:0]           second_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    ptr_q, ptr_d, base;
  logic             do_push;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer after the pop, and whether the push still fits.
  always_comb begin
    base    = (ptr_q >= PW'(pop_n_i)) ? ptr_q - PW'(pop_n_i) : '0;
    do_push = push_i && (base != PW'(DEPTH)) && !clr_i;
    ptr_d   = clr_i ? '0 : base + PW'(do_push);
  end

  // Stack pointer; entries are only meaningful below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Storage write at the post-pop pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[AW'(base)] <= din_i;
  end

  // Top two entries, zero when absent.
  always_comb begin
    top_o    = '0;
    second_o = '0;
    if (ptr_q >= PW'(1)) top_o    = mem_q[AW'(ptr_q - PW'(1))];
    if (ptr_q >= PW'(2)) second_o = mem_q[AW'(ptr_q - PW'(2))];
  end

  assign count_o = ptr_q;
  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);

endmodule

// File: rtl/infix_calc_engine.sv
// infix_calc_engine: streaming infix expression evaluator (shunting-yard).
// Tokens arrive over a valid/ready handshake; results leave over a second
// valid/ready handshake. Optional feature macro: CALC_SUB_EN enables the
// SUB operator (kind 110); without it that kind is a syntax error.
//
// Handshakes: a token transfers on a rising edge where tok_valid and
// tok_ready are both 1 (tok_ready is 1 exactly in ACCEPT); a result
// transfers on a rising edge where res_valid and res_ready are both 1, and
// res_data/res_ovf/res_err are held stable while res_valid waits.
//
// Reductions are fused with the final stack action: the cycle that applies
// the last needed reduction also pushes the pending operator (or pops the
// matching LPAREN), so tok_ready drops for exactly one cycle per reduction.
module infix_calc_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [2:0]       tok_kind,
  input  logic [WIDTH-1:0] tok_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_err,
  output logic             busy
);
  import calc_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  tok_kind_e        pend_q, pend_d;
  logic             err_q, err_d, ovf_q, ovf_d, expect_q, expect_d;
  logic             res_valid_q, res_valid_d, res_ovf_q, res_ovf_d, res_err_q, res_err_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;

  logic             opnd_push, opnd_full, opnd_empty, opnd_pair;
  logic [1:0]       opnd_pop_n;
  logic [WIDTH-1:0] opnd_din, opnd_top, opnd_second;
  logic [CW-1:0]    opnd_count;

  logic             op_push, op_full, op_empty, op_has2;
  logic [1:0]       op_pop_n;
  op_e              op_din, op_top, op_second;
  logic [OP_W-1:0]  op_din_raw, op_top_raw, op_second_raw;
  logic [CW-1:0]    op_count;

  logic             stk_clr, fin_now, fin_err, do_reduce, tok_is_op;
  tok_kind_e        tok_k;
  op_e              tok_op, pend_op;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  calc_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_opnd_stk (
    .clk(clk), .rst(rst), .clr_i(stk_clr), .push_i(opnd_push), .pop_n_i(opnd_pop_n),
    .din_i(opnd_din), .top_o(opnd_top), .second_o(opnd_second), .count_o(opnd_count),
    .full_o(opnd_full), .empty_o(opnd_empty)
  );

  calc_lifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_op_stk (
    .clk(clk), .rst(rst), .clr_i(stk_clr), .push_i(op_push), .pop_n_i(op_pop_n),
    .din_i(op_din_raw), .top_o(op_top_raw), .second_o(op_second_raw), .count_o(op_count),
    .full_o(op_full), .empty_o(op_empty)
  );

  assign op_din_raw = op_din;
  assign op_top     = op_e'(op_top_raw);
  assign op_second  = op_e'(op_second_raw);
  assign op_has2    = !op_empty && (op_count != CW'(1));
  assign opnd_pair  = !opnd_empty && (opnd_count != CW'(1));
  assign tok_k      = tok_kind_e'(tok_kind);
  assign tok_op     = kind_to_op(tok_k);
  assign pend_op    = kind_to_op(pend_q);

`ifdef CALC_SUB_EN
  assign tok_is_op = (tok_k == TK_ADD) || (tok_k == TK_MUL) || (tok_k == TK_SUB);
`else
  assign tok_is_op = (tok_k == TK_ADD) || (tok_k == TK_MUL);
`endif

  // Reduction ALU: second-from-top <op> top, with carry/borrow/high-half flag.
  always_comb begin
    sum     = {1'b0, opnd_second} + {1'b0, opnd_top};
    diff    = {1'b0, opnd_second} - {1'b0, opnd_top};
    prod    = {{WIDTH{1'b0}}, opnd_second} * {{WIDTH{1'b0}}, opnd_top};
    alu_res = sum[WIDTH-1:0];
    alu_ovf = sum[WIDTH];
    case (op_top)
      OP_MUL: begin alu_res = prod[WIDTH-1:0]; alu_ovf = |prod[2*WIDTH-1:WIDTH]; end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_ovf = diff[WIDTH]; end
      default: ;
    endcase
  end

  // Next-state, stack commands and result capture.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    expect_d    = expect_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    opnd_push   = 1'b0;
    opnd_pop_n  = 2'd0;
    opnd_din    = tok_data;
    op_push     = 1'b0;
    op_pop_n    = 2'd0;
    op_din      = tok_op;
    stk_clr     = 1'b0;
    fin_now     = 1'b0;
    fin_err     = 1'b0;
    do_reduce   = 1'b0;

    case (state_q)
      ST_ACCEPT: begin
        if (tok_valid) begin
          pend_d = tok_k;
          if (err_q) begin
            // Discard mode: only END matters, and it reports the error.
            if (tok_k == TK_END) begin fin_now = 1'b1; fin_err = 1'b1; end
          end else if (tok_is_op) begin
            if (expect_q) err_d = 1'b1;
            else if (!op_empty && op_top != OP_LPAREN && op_prec(op_top) >= op_prec(tok_op))
              state_d = ST_REDUCE;
            else if (op_full) err_d = 1'b1;
            else begin op_push = 1'b1; expect_d = 1'b1; end
          end else begin
            case (tok_k)
              TK_OPERAND: begin
                if (!expect_q || opnd_full) err_d = 1'b1;
                else begin opnd_push = 1'b1; expect_d = 1'b0; end
              end
              TK_LPAREN: begin
                if (!expect_q || op_full) err_d = 1'b1;
                else op_push = 1'b1;
              end
              TK_RPAREN: begin
                if (expect_q || op_empty) err_d = 1'b1;
                else if (op_top == OP_LPAREN) op_pop_n = 2'd1;
                else state_d = ST_REDUCE;
              end
              TK_END: begin
                if (expect_q) begin fin_now = 1'b1; fin_err = 1'b1; end
                else state_d = ST_FINISH;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end

      ST_REDUCE: begin
        if (!opnd_pair) begin
          err_d   = 1'b1;
          state_d = ST_ACCEPT;
        end else begin
          do_reduce = 1'b1;
          op_pop_n  = 2'd1;
          if (pend_q == TK_RPAREN) begin
            if (!op_has2) begin err_d = 1'b1; state_d = ST_ACCEPT; end
            else if (op_second == OP_LPAREN) begin op_pop_n = 2'd2; state_d = ST_ACCEPT; end
          end else if (!(op_has2 && op_second != OP_LPAREN &&
                         op_prec(op_second) >= op_prec(pend_op))) begin
            op_push  = 1'b1;
            op_din   = pend_op;
            expect_d = 1'b1;
            state_d  = ST_ACCEPT;
          end
        end
      end

      ST_FINISH: begin
        if (op_empty) begin
          fin_now = 1'b1;
          fin_err = err_q || (opnd_count != CW'(1));
        end else if (op_top == OP_LPAREN || !opnd_pair) begin
          fin_now = 1'b1;
          fin_err = 1'b1;
        end else begin
          do_reduce = 1'b1;
          op_pop_n  = 2'd1;
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          stk_clr     = 1'b1;
          state_d     = ST_ACCEPT;
          err_d       = 1'b0;
          ovf_d       = 1'b0;
          expect_d    = 1'b1;
          res_valid_d = 1'b0;
          res_data_d  = '0;
          res_ovf_d   = 1'b0;
          res_err_d   = 1'b0;
        end
      end

      default: state_d = ST_ACCEPT;
    endcase

    if (do_reduce) begin
      opnd_pop_n = 2'd2;
      opnd_push  = 1'b1;
      opnd_din   = alu_res;
      ovf_d      = ovf_q | alu_ovf;
    end

    if (fin_now) begin
      state_d     = ST_RESULT;
      res_valid_d = 1'b1;
      res_err_d   = fin_err;
      res_data_d  = fin_err ? '0 : opnd_top;
      res_ovf_d   = !fin_err && ovf_q;
    end
  end

  // FSM and flag registers; reset discards any expression in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      pend_q      <= TK_END;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      expect_q    <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      expect_q    <= expect_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
    end
  end

  assign tok_ready = (state_q == ST_ACCEPT);
  assign busy      = (state_q != ST_ACCEPT);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_err   = res_err_q;

endmodule
